// File: rtl/data_mem_io.sv
// data_mem_io: CPU data-port responder mapping data RAM and DE10-Lite board I/O.
// Reads are combinational from data_addr; writes commit on the rising clock edge.
module data_mem_io #(
    parameter int RAM_WORDS       = 16384,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMER_DIV       = 50000
) (
    input  logic        CPUclk,
    input  logic        rst,
    input  logic [14:0] data_addr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] rdata,
    input  logic [9:0]  sw_in,
    input  logic [1:0]  key_n,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic [7:0]  hex2,
    output logic [7:0]  hex3,
    output logic [7:0]  hex4,
    output logic [7:0]  hex5,
    output logic [9:0]  ledr
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMER_DIV + 1);

    localparam logic [15:0]   RAM_END = 16'(RAM_WORDS);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TD_LAST = TW'(TIMER_DIV - 1);

    localparam logic [14:0] A_LEDR  = 15'h6000;
    localparam logic [14:0] A_SW    = 15'h6001;
    localparam logic [14:0] A_KEY   = 15'h6002;
    localparam logic [14:0] A_TIMER = 15'h6003;

    logic [15:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_hex [6];
    logic [9:0]    r_ledr;
    logic [9:0]    r_sw_s1;
    logic [9:0]    r_sw_s2;
    logic [1:0]    r_key_s1;
    logic [1:0]    r_key_s2;
    logic [1:0]    r_key_lvl;
    logic [1:0]    r_key_stk;
    logic [DW-1:0] r_db_cnt [2];
    logic [15:0]   r_tmr;
    logic [TW-1:0] r_presc;

    logic          w_ram_sel;
    logic          w_hex_sel;
    logic          w_led_sel;
    logic          w_sw_sel;
    logic          w_key_sel;
    logic          w_tmr_sel;
    logic [2:0]    w_hex_idx;
    logic [AW-1:0] w_ram_idx;
    logic [1:0]    w_key_qual;
    logic [1:0]    w_key_rise;
    logic [1:0]    w_key_clr;

    // Address decode
    assign w_ram_sel = {1'b0, data_addr} < RAM_END;
    assign w_ram_idx = data_addr[AW-1:0];
    assign w_hex_idx = data_addr[2:0];
    assign w_hex_sel = (data_addr[14:3] == 12'h800) && (w_hex_idx < 3'd6);
    assign w_led_sel = (data_addr == A_LEDR);
    assign w_sw_sel  = (data_addr == A_SW);
    assign w_key_sel = (data_addr == A_KEY);
    assign w_tmr_sel = (data_addr == A_TIMER);

    // RAM keeps its contents across reset, so writes ignore rst
    always_ff @(posedge CPUclk) begin
        if (we && w_ram_sel) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    always_ff @(posedge CPUclk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                r_hex[i] <= 8'hFF;
            end
            r_ledr <= '0;
        end else if (we) begin
            if (w_hex_sel) begin
                r_hex[w_hex_idx] <= wdata[7:0];
            end
            if (w_led_sel) begin
                r_ledr <= wdata[9:0];
            end
        end
    end

    always_ff @(posedge CPUclk) begin
        if (rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw_in;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // A key qualifies on the cycle its counter is at the last count and still differs
    always_comb begin
        w_key_qual = '0;
        for (int k = 0; k < 2; k++) begin
            w_key_qual[k] = (r_key_s2[k] != r_key_lvl[k]) && (r_db_cnt[k] == DB_LAST);
        end
    end

    assign w_key_rise = w_key_qual & r_key_s2;
    assign w_key_clr  = (we && w_key_sel) ? wdata[9:8] : 2'b00;

    always_ff @(posedge CPUclk) begin
        if (rst) begin
            r_key_s1  <= '0;
            r_key_s2  <= '0;
            r_key_lvl <= '0;
            r_key_stk <= '0;
            for (int k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_key_s1 <= ~key_n;
            r_key_s2 <= r_key_s1;
            for (int k = 0; k < 2; k++) begin
                if (w_key_qual[k]) begin
                    r_key_lvl[k] <= r_key_s2[k];
                    r_db_cnt[k]  <= '0;
                end else if (r_key_s2[k] == r_key_lvl[k]) begin
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DW'(1);
                end
            end
            r_key_stk <= (r_key_stk & ~w_key_clr) | w_key_rise;
        end
    end

    always_ff @(posedge CPUclk) begin
        if (rst) begin
            r_tmr   <= '0;
            r_presc <= '0;
        end else if (we && w_tmr_sel) begin
            r_tmr   <= wdata;
            r_presc <= '0;
        end else if (r_presc == TD_LAST) begin
            r_tmr   <= r_tmr + 16'd1;
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TW'(1);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            w_ram_sel: rdata = r_ram[w_ram_idx];
            w_hex_sel: rdata = {8'h00, r_hex[w_hex_idx]};
            w_led_sel: rdata = {6'h00, r_ledr};
            w_sw_sel:  rdata = {6'h00, r_sw_s2};
            w_key_sel: rdata = {6'h00, r_key_stk, 6'h00, r_key_lvl};
            w_tmr_sel: rdata = r_tmr;
            default:   rdata = '0;
        endcase
    end

    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];
    assign hex4 = r_hex[4];
    assign hex5 = r_hex[5];
    assign ledr = r_ledr;

endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: directed plus randomized checks of data_mem_io
// against a cycle-level behavioural model of the memory map.
module tb_data_mem_io;

    localparam int RW = 1024;
    localparam int DB = 8;
    localparam int TD = 4;

    logic        CPUclk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] data_addr = '0;
    logic [15:0] wdata = '0;
    logic        we = 1'b0;
    logic [15:0] rdata;
    logic [9:0]  sw_in = '0;
    logic [1:0]  key_n = 2'b11;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  ledr;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ram [int];
    logic [7:0]  m_hex [6];
    logic [9:0]  m_ledr;
    logic [9:0]  m_sw_p1, m_sw_p2;
    logic [1:0]  m_key_p1, m_key_p2;
    logic [1:0]  m_lvl, m_stk, m_prev;
    int          m_run [2];
    logic [15:0] m_tbase;
    int          m_since;

    always #10 CPUclk = ~CPUclk;

    data_mem_io #(
        .RAM_WORDS(RW),
        .DEBOUNCE_CYCLES(DB),
        .TIMER_DIV(TD)
    ) dut (
        .CPUclk(CPUclk),
        .rst(rst),
        .data_addr(data_addr),
        .wdata(wdata),
        .we(we),
        .rdata(rdata),
        .sw_in(sw_in),
        .key_n(key_n),
        .hex0(hex0),
        .hex1(hex1),
        .hex2(hex2),
        .hex3(hex3),
        .hex4(hex4),
        .hex5(hex5),
        .ledr(ledr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model update for one rising edge, using the inputs present before it
    task automatic model_edge();
        logic [1:0] smp;
        logic [1:0] rise;
        smp  = m_key_p2;
        rise = 2'b00;
        if (int'(data_addr) < RW && we) m_ram[int'(data_addr)] = wdata;
        if (rst) begin
            for (int i = 0; i < 6; i++) m_hex[i] = 8'hFF;
            m_ledr = '0;
            m_sw_p1 = '0;
            m_sw_p2 = '0;
            m_key_p1 = '0;
            m_key_p2 = '0;
            m_lvl = '0;
            m_stk = '0;
            m_prev = '0;
            m_run[0] = 0;
            m_run[1] = 0;
            m_tbase = '0;
            m_since = 0;
            return;
        end
        // level follows a synced sample once it has differed for DB straight edges
        for (int k = 0; k < 2; k++) begin
            if (smp[k] == m_prev[k]) m_run[k]++;
            else m_run[k] = 1;
            m_prev[k] = smp[k];
            if (smp[k] != m_lvl[k] && m_run[k] >= DB) begin
                m_lvl[k] = smp[k];
                rise[k] = smp[k];
            end
        end
        if (we && data_addr == 15'h6002) m_stk = m_stk & ~wdata[9:8];
        m_stk = m_stk | rise;
        m_sw_p2 = m_sw_p1;
        m_sw_p1 = sw_in;
        m_key_p2 = m_key_p1;
        m_key_p1 = ~key_n;
        if (we && data_addr >= 15'h4000 && data_addr <= 15'h4005)
            m_hex[int'(data_addr) - 'h4000] = wdata[7:0];
        if (we && data_addr == 15'h6000) m_ledr = wdata[9:0];
        if (we && data_addr == 15'h6003) begin
            m_tbase = wdata;
            m_since = 0;
        end else begin
            m_since++;
        end
    endtask

    // {known, value}
    function automatic logic [16:0] exp_rd(input logic [14:0] a);
        logic [15:0] t;
        if (int'(a) < RW) begin
            if (m_ram.exists(int'(a))) return {1'b1, m_ram[int'(a)]};
            return 17'h00000;
        end
        if (a >= 15'h4000 && a <= 15'h4005) return {1'b1, 8'h00, m_hex[int'(a) - 'h4000]};
        t = m_tbase + 16'(m_since / TD);
        case (a)
            15'h6000: return {1'b1, 6'h00, m_ledr};
            15'h6001: return {1'b1, 6'h00, m_sw_p2};
            15'h6002: return {1'b1, 6'h00, m_stk, 6'h00, m_lvl};
            15'h6003: return {1'b1, t};
            default:  return 17'h10000;
        endcase
    endfunction

    task automatic check_all();
        logic [16:0] e;
        e = exp_rd(data_addr);
        if (e[16]) chk($sformatf("rdata@%h", data_addr), 64'(rdata), 64'(e[15:0]));
        chk("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
            64'({m_hex[5], m_hex[4], m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
        chk("ledr", 64'(ledr), 64'(m_ledr));
    endtask

    task automatic cycle();
        @(posedge CPUclk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        data_addr = a;
        wdata = d;
        we = 1'b1;
        cycle();
        we = 1'b0;
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string tag);
        data_addr = a;
        we = 1'b0;
        #1;
        chk(tag, 64'(rdata), 64'(exp));
    endtask

    logic [14:0] odd_addr [4];

    initial begin
        odd_addr[0] = 15'h03FF;
        odd_addr[1] = 15'h0400;
        odd_addr[2] = 15'h5000;
        odd_addr[3] = 15'h7FFF;

        rst = 1'b1;
        repeat (3) cycle();
        chk("hex_rst", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'h0000_FFFF_FFFF_FFFF);
        chk("ledr_rst", 64'(ledr), 64'h0);
        rst = 1'b0;

        wr(15'h0006, 16'hBEEF);
        wr(15'h0005, 16'h1234);
        rd(15'h0005, 16'h1234, "ram5");
        rd(15'h0006, 16'hBEEF, "ram6");
        wr(15'h5000, 16'hAAAA);
        rd(15'h5000, 16'h0000, "unmapped");
        wr(15'h03FF, 16'h55AA);
        rd(15'h03FF, 16'h55AA, "ram_top");
        wr(15'h0400, 16'h1111);
        rd(15'h0400, 16'h0000, "ram_end");
        rd(15'h4003, 16'h00FF, "hex3_rst");

        wr(15'h4002, 16'h00C0);
        chk("hex2", 64'(hex2), 64'hC0);
        rd(15'h4002, 16'h00C0, "hex2_rd");
        wr(15'h6000, 16'h03FF);
        chk("ledr_wr", 64'(ledr), 64'h3FF);
        rd(15'h6000, 16'h03FF, "ledr_rd");

        sw_in = 10'h2AA;
        data_addr = 15'h6001;
        cycle();
        chk("sw_1edge", 64'(rdata), 64'h0);
        cycle();
        chk("sw_2edge", 64'(rdata), 64'h2AA);

        data_addr = 15'h6002;
        key_n = 2'b10;
        repeat (5) cycle();
        key_n = 2'b11;
        repeat (12) cycle();
        chk("glitch", 64'(rdata), 64'h0);
        key_n = 2'b10;
        repeat (12) cycle();
        chk("press", 64'(rdata), 64'h0101);
        wr(15'h6002, 16'h0100);
        rd(15'h6002, 16'h0001, "w1c");
        key_n = 2'b11;
        repeat (12) cycle();
        rd(15'h6002, 16'h0000, "release");

        key_n = 2'b01;
        repeat (9) cycle();
        chk("k1_pre", 64'(rdata), 64'h0);
        wr(15'h6002, 16'h0300);
        rd(15'h6002, 16'h0202, "set_wins");
        wr(15'h6002, 16'h0200);
        rd(15'h6002, 16'h0002, "k1_clr");
        key_n = 2'b11;
        repeat (12) cycle();

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        data_addr = 15'h6003;
        repeat (40) cycle();
        chk("tmr40", 64'(rdata), 64'd10);
        wr(15'h6003, 16'hFFFF);
        repeat (4) cycle();
        chk("tmr_wrap", 64'(rdata), 64'h0);
        for (int i = 0; i < TD && (m_since % TD) != TD - 1; i++) cycle();
        wr(15'h6003, 16'h0007);
        rd(15'h6003, 16'h0007, "tmr_load");
        repeat (3) cycle();
        chk("tmr_hold", 64'(rdata), 64'h7);
        cycle();
        chk("tmr_inc", 64'(rdata), 64'h8);

        wr(15'h0010, 16'h0123);
        wr(15'h6000, 16'h0155);
        data_addr = 15'h6000;
        wdata = 16'h03FF;
        we = 1'b1;
        rst = 1'b1;
        cycle();
        chk("ledr_rst_wr", 64'(ledr), 64'h0);
        data_addr = 15'h0011;
        wdata = 16'h4321;
        cycle();
        we = 1'b0;
        rst = 1'b0;
        rd(15'h0010, 16'h0123, "ram_keep");
        rd(15'h0011, 16'h4321, "ram_rst_wr");
        rd(15'h6002, 16'h0000, "key_rst");

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 15) == 0) key_n[k] = ~key_n[k];
            end
            if ($urandom_range(0, 49) == 0) sw_in = 10'($urandom);
            case ($urandom_range(0, 5))
                0: data_addr = 15'($urandom_range(0, 15));
                1: data_addr = 15'h4000 + 15'($urandom_range(0, 7));
                2: data_addr = 15'h6000 + 15'($urandom_range(0, 4));
                3: data_addr = 15'h6002;
                4: data_addr = 15'h6003;
                default: data_addr = odd_addr[$urandom_range(0, 3)];
            endcase
            we = ($urandom_range(0, 2) == 0);
            wdata = 16'($urandom);
            cycle();
        end
        rst = 1'b0;
        we = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Responder on the CPU data port. Serves data_addr, wdata, we and rdata.
- Maps on-chip data RAM plus DE10-Lite board I/O into the CPU's 15-bit data address space: six seven-segment HEX registers, LEDs, switches, KEY status with debounce and sticky press flags, and a millisecond timer.
- Sits between the CPU core and the board pins in the top level. Matches the CPU's single-cycle model: combinational read, write committed on the clock edge.

Parameters:
- RAM_WORDS, 16384, number of 16-bit RAM words. Decoded at 0x0000..RAM_WORDS-1. Must be ≤ 0x4000.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles (5 ms at 50 MHz) before a KEY level change is accepted.
- TIMER_DIV, 50000, clock cycles per timer tick (1 ms at 50 MHz).

Ports:
- CPUclk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- data_addr  in  15  CPU data address.
- wdata  in  16  CPU write data.
- we  in  1  CPU write enable; write occurs at posedge CPUclk when high.
- rdata  out  16  read data; combinational from data_addr.
- sw_in  in  10  raw board switches, asynchronous.
- key_n  in  2  raw board keys, active-low, asynchronous.
- hex0..hex5  out  8 each  segment drive, active-low, bit 7 = DP.
- ledr  out  10  LED drive.

Behaviour:
Address map (any other address: reads 0x0000, writes ignored):
- 0x0000..RAM_WORDS-1: RAM. Read/write.
- 0x4000..0x4005: HEX0..HEX5. Write uses wdata[7:0]. Read returns {8'h00, reg}.
- 0x6000: LEDR. Write uses wdata[9:0]. Read is zero-extended.
- 0x6001: SW. Read-only; returns the synchronized value, zero-extended.
- 0x6002: KEY status, with these bits:
  - [1:0] debounced level, 1 = pressed.
  - [9:8] sticky press flags.
  - Other bits read 0.
  - Write: each wdata[9:8] bit that is 1 clears that flag (W1C).
- 0x6003: TIMER, 16-bit. Read returns the count. Write loads wdata and clears the prescaler.

Read and write timing:
- rdata is purely combinational from data_addr and current state.
- A write is visible on the read in the cycle after its clock edge.
- RAM has no byte enables. Writes are full 16-bit.

Reset values (rst high at posedge):
- hex0..hex5 = 8'hFF (blank).
- ledr = 0.
- SW sync flops = 0.
- Debounced KEY level = 0, debounce counters = 0, sticky flags = 0.
- TIMER = 0, prescaler = 0.
- RAM contents are not cleared; they keep their value across reset.
- Reset mid-operation: a write coincident with rst is dropped for registers and still performed for RAM.

SW path:
- Two-flop synchronizer per bit.
- A pin change appears on the 0x6001 read after 2 clock edges.

KEY path, per key:
- Two-flop synchronizer on ~key_n.
- States: STABLE (counter = 0) and COUNTING.
- If the synchronized sample differs from the debounced level, the counter increments. If it equals the level, the counter resets to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 while the sample still differs, the level takes the sample and the counter resets to 0.
- A 0→1 level transition sets the sticky flag.
- Glitches shorter than DEBOUNCE_CYCLES never change the level.
- Set and W1C on the same cycle: set wins, so an event is never lost.

TIMER:
- Prescaler counts 0..TIMER_DIV-1. On wrap, TIMER increments.
- TIMER wraps 0xFFFF→0x0000 silently.
- CPU write and tick on the same cycle: the write wins and the prescaler restarts at 0.

Test Plan:
- RAM: write 0x1234 to 0x0005, then read 0x0005 next cycle → 0x1234. Read 0x0006 → previous content. Write then read 0x5000 → 0x0000.
- I/O regs: after rst, hex0..5 = 0xFF and ledr = 0.
  - Write 0x00C0 to 0x4002 → hex2 = 0xC0.
  - Write 0x03FF to 0x6000 → ledr = 0x3FF; read returns 0x03FF.
- Debounce: use DEBOUNCE_CYCLES = 8.
  - Hold key_n[0] low for 5 cycles, then high → 0x6002 stays 0x0000.
  - Hold low for 12 cycles → bit0 = 1 and bit8 = 1 (read 0x0101).
  - Write 0x0100 → read 0x0001.
- Set vs clear: write 0x0300 to 0x6002 in the same cycle that key1 qualifies → bit9 remains 1.
- Timer: use TIMER_DIV = 4.
  - After rst, 40 cycles → TIMER = 10.
  - Write 0xFFFF, wait 4 cycles → 0x0000.
  - Write 0x0007 on a tick cycle → reads 0x0007, next increment 4 cycles later.
- SW and reset: toggle sw_in to 0x2AA → read 0x6001 = 0x02AA after 2 edges.
  - Assert rst while we writes LEDR → ledr = 0 and the RAM word at a pre-written address is preserved.
